// File: rtl/mem_arbiter.sv
// N-channel round-robin arbiter from L1 cache ports onto a single next-level memory port.
// Define MEM_ARB_FIXED_PRIO_EN for legacy fixed priority (lowest channel index always wins).
module mem_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_read,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_address,
  input  logic [NUM_CH*LINE_W-1:0] req_wdata,
  output logic [LINE_W-1:0]        req_rdata,
  output logic [NUM_CH-1:0]        req_resp,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic [ADDR_W-1:0]        pmem_address,
  output logic [LINE_W-1:0]        pmem_wdata,
  input  logic                     pmem_resp,
  input  logic [LINE_W-1:0]        pmem_rdata
);

  localparam int unsigned GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [GW-1:0] LastCh = GW'(NUM_CH - 1);
  localparam logic [GW:0]   NumChW = (GW + 1)'(NUM_CH);

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_t;

  state_t              r_state, w_state_next;
  logic [GW-1:0]       r_grant, w_grant_next;
  logic                r_op_write, w_op_write_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [LINE_W-1:0]   r_wdata, w_wdata_next;

  logic [NUM_CH-1:0]   w_req_vec;
  logic [NUM_CH-1:0]   w_rot;
  logic [GW-1:0]       w_scan_base;
  logic [GW-1:0]       w_offset;
  logic [GW:0]         w_sum;
  logic [GW-1:0]       w_winner;
  logic                w_any_req;
  logic                w_resp;

  logic [ADDR_W-1:0]   w_addr_arr  [NUM_CH];
  logic [LINE_W-1:0]   w_wdata_arr [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign w_addr_arr[g]  = req_address[g*ADDR_W +: ADDR_W];
    assign w_wdata_arr[g] = req_wdata[g*LINE_W +: LINE_W];
  end

  assign w_req_vec = req_read | req_write;
  assign w_any_req = |w_req_vec;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign w_scan_base = '0;
`else
  logic [GW-1:0] r_rr_ptr, w_rr_ptr_next;

  assign w_scan_base = r_rr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else begin
      r_rr_ptr <= w_rr_ptr_next;
    end
  end
`endif

  // Rotate so that bit 0 is the channel at the scan base; first set bit is the winner offset.
  always_comb begin
    w_rot    = NUM_CH'({w_req_vec, w_req_vec} >> w_scan_base);
    w_offset = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_offset = GW'(k);
      end
    end
    w_sum = {1'b0, w_scan_base} + {1'b0, w_offset};
    if (w_sum >= NumChW) begin
      w_sum = w_sum - NumChW;
    end
    w_winner = w_sum[GW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_grant    <= '0;
      r_op_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_grant    <= w_grant_next;
      r_op_write <= w_op_write_next;
      r_addr     <= w_addr_next;
      r_wdata    <= w_wdata_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_grant_next    = r_grant;
    w_op_write_next = r_op_write;
    w_addr_next     = r_addr;
    w_wdata_next    = r_wdata;
`ifndef MEM_ARB_FIXED_PRIO_EN
    w_rr_ptr_next   = r_rr_ptr;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_state_next    = StBusy;
          w_grant_next    = w_winner;
          // Write takes precedence when a channel raises both strobes.
          w_op_write_next = req_write[w_winner];
          w_addr_next     = w_addr_arr[w_winner];
          w_wdata_next    = w_wdata_arr[w_winner];
        end
      end
      StBusy: begin
        if (pmem_resp) begin
          w_state_next = StIdle;
`ifndef MEM_ARB_FIXED_PRIO_EN
          w_rr_ptr_next = (r_grant == LastCh) ? '0 : r_grant + 1'b1;
`endif
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign w_resp       = (r_state == StBusy) && pmem_resp;
  assign pmem_read    = (r_state == StBusy) && !r_op_write;
  assign pmem_write   = (r_state == StBusy) && r_op_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign req_rdata    = pmem_rdata;
  assign req_resp     = w_resp ? (NUM_CH'(1) << r_grant) : '0;

`ifndef SYNTHESIS
  a_resp_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_resp));
  a_strobe_excl: assert property (@(posedge clk) disable iff (reset) !(pmem_read && pmem_write));
  a_grant_range: assert property (@(posedge clk) disable iff (reset) r_grant <= LastCh);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a queue-based reference model.
module tb_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int LW = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_read, req_write;
  logic [N*AW-1:0]   req_address;
  logic [N*LW-1:0]   req_wdata;
  logic [LW-1:0]     req_rdata;
  logic [N-1:0]      req_resp;
  logic              pmem_read, pmem_write;
  logic [AW-1:0]     pmem_address;
  logic [LW-1:0]     pmem_wdata;
  logic              pmem_resp;
  logic [LW-1:0]     pmem_rdata;

  logic [AW-1:0]     ch_addr  [N];
  logic [LW-1:0]     ch_wdata [N];

  always #5 clk = ~clk;

  always_comb begin
    req_address = '0;
    req_wdata   = '0;
    for (int i = 0; i < N; i++) begin
      req_address[i*AW +: AW] = ch_addr[i];
      req_wdata[i*LW +: LW]   = ch_wdata[i];
    end
  end

  mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_address  (req_address),
    .req_wdata    (req_wdata),
    .req_rdata    (req_rdata),
    .req_resp     (req_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  typedef struct {
    int          ch;
    bit          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  int   grant_log[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: one outstanding transaction, rotating pointer.
  bit m_busy = 0;
  int m_ch   = 0;
  bit m_wr   = 0;
  int m_ptr  = 0;

  bit [N-1:0] en_mask  = '0;
  bit         sat      = 0;
  bit         stray_en = 0;
  int         drop_pct = 0;
  bit         log_en   = 0;

  bit act      [N];
  bit drop     [N];
  int idle_cnt [N];
  int wait_cnt [N];

  task automatic check(input string name, input logic [LW-1:0] act_v, input logic [LW-1:0] exp_v);
    n_checks++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act_v, exp_v);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: got timeout required completion", name);
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: advances once per clock from the sampled request levels.
  initial begin
    int c;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_busy = 0;
        m_ptr  = 0;
        exp_q.delete();
      end else if (m_busy) begin
        if (pmem_resp) begin
          m_busy = 0;
`ifndef MEM_ARB_FIXED_PRIO_EN
          m_ptr = (m_ch + 1) % N;
`endif
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (!m_busy && (req_read[c] || req_write[c])) begin
            txn_t t;
            m_busy  = 1;
            m_ch    = c;
            m_wr    = req_write[c];
            t.ch    = c;
            t.wr    = req_write[c];
            t.addr  = ch_addr[c];
            t.wdata = ch_wdata[c];
            exp_q.push_back(t);
          end
        end
      end
    end
  end

  // Memory responder: random latency per transaction, optional stray pulses while idle.
  initial begin
    int cnt = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (reset) begin
        cnt = $urandom_range(0, 3);
      end else if (pmem_read || pmem_write) begin
        if (cnt == 0) begin
          pmem_resp  = 1'b1;
          pmem_rdata = rand_line();
          cnt        = $urandom_range(0, 3);
        end else begin
          cnt--;
        end
      end else begin
        cnt = $urandom_range(0, 3);
        if (stray_en && $urandom_range(0, 5) == 0) begin
          pmem_resp  = 1'b1;
          pmem_rdata = rand_line();
        end
      end
    end
  end

  // Channel drivers: hold each request until its resp pulse.
  initial begin
    logic [N-1:0] seen;
    int op;
    req_read  = '0;
    req_write = '0;
    for (int i = 0; i < N; i++) begin
      ch_addr[i]  = '0;
      ch_wdata[i] = '0;
      act[i]      = 0;
      drop[i]     = 0;
      idle_cnt[i] = 0;
      wait_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      seen = req_resp;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (reset) begin
          act[i]       = 0;
          req_read[i]  = 1'b0;
          req_write[i] = 1'b0;
          idle_cnt[i]  = 0;
        end else if (act[i]) begin
          if (seen[i]) begin
            wait_cnt[i] = 0;
            if (!sat) begin
              act[i]       = 0;
              req_read[i]  = 1'b0;
              req_write[i] = 1'b0;
              idle_cnt[i]  = $urandom_range(0, 4);
            end
          end else if (drop[i] && m_busy && m_ch == i) begin
            req_read[i]  = 1'b0;
            req_write[i] = 1'b0;
          end else begin
            wait_cnt[i]++;
            if (wait_cnt[i] > 100) begin
              fail("chan_resp_wait");
              act[i]       = 0;
              req_read[i]  = 1'b0;
              req_write[i] = 1'b0;
            end
          end
        end else if (idle_cnt[i] > 0) begin
          idle_cnt[i]--;
        end else if (en_mask[i]) begin
          op           = $urandom_range(0, 2);
          act[i]       = 1;
          wait_cnt[i]  = 0;
          req_read[i]  = (op != 1);
          req_write[i] = (op != 0);
          ch_addr[i]   = AW'($urandom);
          ch_wdata[i]  = rand_line();
          drop[i]      = ($urandom_range(0, 99) < drop_pct);
        end
      end
    end
  end

  // Monitor: per-cycle strobe/resp timing plus scoreboard pop on each new transaction.
  initial begin
    bit           prev_strobe = 0;
    bit           strobe;
    txn_t         cur;
    logic [N-1:0] exp_resp;
    cur.ch = 0; cur.wr = 0; cur.addr = '0; cur.wdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_strobe = 0;
      end else begin
        exp_resp = (m_busy && pmem_resp) ? (N'(1) << m_ch) : '0;
        check("pmem_read_timing", LW'(pmem_read), LW'(m_busy && !m_wr));
        check("pmem_write_timing", LW'(pmem_write), LW'(m_busy && m_wr));
        check("req_resp_timing", LW'(req_resp), LW'(exp_resp));
        strobe = pmem_read || pmem_write;
        if (strobe && !prev_strobe) begin
          if (exp_q.size() == 0) begin
            check("unexpected_txn", LW'(1), LW'(0));
          end else begin
            cur = exp_q.pop_front();
            check("txn_is_write", LW'(pmem_write), LW'(cur.wr));
            check("txn_address", LW'(pmem_address), LW'(cur.addr));
            if (cur.wr) check("txn_wdata", pmem_wdata, cur.wdata);
          end
        end
        if (strobe && pmem_resp) begin
          check("resp_channel", LW'(req_resp), LW'(N'(1) << cur.ch));
          check("resp_rdata", req_rdata, pmem_rdata);
          if (log_en) begin
            for (int k = 0; k < N; k++) if (req_resp[k]) grant_log.push_back(k);
          end
        end
        prev_strobe = strobe;
      end
    end
  end

  task automatic drain();
    int t = 0;
    while ((act[0] || act[1] || act[2] || m_busy) && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (t >= 300) fail("drain");
  endtask

  initial begin
    int t;
    int exp_ch;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pmem_read", LW'(pmem_read), '0);
    check("rst_pmem_write", LW'(pmem_write), '0);
    check("rst_req_resp", LW'(req_resp), '0);
    check("rst_pmem_address", LW'(pmem_address), '0);
    check("rst_pmem_wdata", pmem_wdata, '0);
    reset = 1'b0;

    // Stray responses with no requests must be ignored.
    stray_en = 1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("stray_idle_strobes", LW'({pmem_read, pmem_write}), '0);

    // Randomized traffic with drops during BUSY.
    en_mask  = '1;
    drop_pct = 20;
    repeat (3000) @(posedge clk);
    en_mask  = '0;
    stray_en = 0;
    drain();

    // Complete one ch1 transaction so the pointer moves away from 0.
    drop_pct = 0;
    en_mask  = 3'b010;
    t = 0;
    while (!m_busy && t < 50) begin @(posedge clk); t++; end
    en_mask = '0;
    drain();

    // Reset in the middle of a ch1 transaction.
    en_mask = 3'b010;
    t = 0;
    @(negedge clk);
    while (!(m_busy && m_ch == 1 && !pmem_resp) && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail("reset_busy_wait");
    check("busy_before_reset", LW'(pmem_read || pmem_write), LW'(1));
    #2 reset = 1'b1;
    #1;
    check("reset_drops_read", LW'(pmem_read), '0);
    check("reset_drops_write", LW'(pmem_write), '0);
    check("reset_no_resp", LW'(req_resp), '0);
    en_mask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // All channels hold requests continuously; record grant order.
    grant_log.delete();
    sat     = 1;
    log_en  = 1;
    en_mask = '1;
    t = 0;
    while (grant_log.size() < 6 && t < 200) begin @(posedge clk); t++; end
    if (t >= 200) fail("saturate_grants");
    for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_ch = 0;
`else
      exp_ch = k % N;
`endif
      check("grant_order", LW'(grant_log[k]), LW'(exp_ch));
    end
    sat     = 0;
    log_en  = 0;
    en_mask = '0;
    drain();
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
